cmd_arbiter: RTL and testbench
==============================

CMD_ARBITER -- requirements
Module: cmd_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named sd_clock and reset.
REQ-002 Parameter: WDT_CYCLES, 16'd2048, watchdog limit in sd_clock cycles per command.
REQ-003 Ports (name  direction  width  meaning):
- sd_clock  in  1  clock
- reset  in  1  synchronous active-high reset
- req0_valid  in  1  host register command request
- req0_cmd  in  40  host command (start, dir, index[37:32], arg, no CRC)
- req0_grant  out  1  one-cycle acceptance pulse
- req0_done  out  1  one-cycle completion pulse
- req1_valid  in  1  data-layer command request (e.g. CMD12)
- req1_cmd  in  40  data-layer command
- req1_grant  out  1  one-cycle acceptance pulse
- req1_done  out  1  one-cycle completion pulse
- resp_data  out  136  latched response, valid with a done pulse
- resp_timeout  out  1  set with a done pulse if the command timed out
- strobe_in  out  1  to cmd_phys: command request
- ack_in  out  1  to cmd_phys: response accepted
- idle_in  out  1  to cmd_phys: force idle
- cmd_to_send  out  40  to cmd_phys: command frame
- ack_out  in  1  from cmd_phys: command accepted
- strobe_out  in  1  from cmd_phys: response available
- response  in  136  from cmd_phys
- serialReady  in  1  from cmd_phys: line free
- COMMAND_TIMEOUT  in  1  from cmd_phys: no response

Function
REQ-004 FSM states: IDLE, ISSUE, WAIT_RESP, ACK, ABORT, DONE; all outputs SHALL be registered.
REQ-005 IDLE: idle_in=1; when any reqN_valid=1 and serialReady=1, the block SHALL select one requester, latch its cmd into cmd_to_send, pulse reqN_grant, and enter ISSUE.
REQ-006 Arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins; after reset, req0 wins.
REQ-007 A requester SHALL hold valid and cmd stable until grant; dropping valid before grant withdraws the request without side effects.
REQ-008 ISSUE: strobe_in=1, idle_in=0; on ack_out=1, strobe_in SHALL drop the next cycle and the FSM SHALL enter WAIT_RESP.
REQ-009 WAIT_RESP exits, in priority order:
- COMMAND_TIMEOUT=1: enter DONE with resp_timeout=1.
- strobe_out=1: latch response into resp_data and enter ACK.
- Latched index in {0,4,15} and serialReady=1: enter DONE with resp_data=0 and resp_timeout=0.
REQ-010 ACK: ack_in=1 until strobe_out=0, then ack_in=0 and enter DONE.
REQ-011 DONE SHALL last exactly one cycle: pulse done of the granted requester, keep resp_data/resp_timeout stable until the next grant, then return to IDLE.
REQ-012 Watchdog: a 16-bit counter SHALL clear on grant and increment in ISSUE and WAIT_RESP; when it reaches WDT_CYCLES, the FSM SHALL enter ABORT regardless of other inputs that cycle.
REQ-013 ABORT: strobe_in=0, ack_in=0, idle_in=1 for one cycle, then DONE with resp_timeout=1 and resp_data=0.
REQ-014 Latency: grant to the first strobe_in=1 cycle SHALL be 1 cycle; the last response event to done SHALL be at most 2 cycles.
REQ-015 A new request SHALL NOT be granted in the DONE cycle; the earliest re-grant is the first IDLE cycle.
REQ-016 At most one of req0_grant, req1_grant, req0_done, req1_done SHALL be high in any cycle.

Reset
REQ-017 Reset SHALL set the state to IDLE and clear the round-robin pointer (req0 favoured) and the watchdog.
REQ-018 Reset SHALL clear all outputs to 0 (idle_in=0 during reset, 1 from the first post-reset cycle).
REQ-019 Reset mid-command SHALL abandon the command without issuing a done pulse.

Structure
REQ-020 A shared package cmd_arb_pkg SHALL hold the state encoding, CMD_W=40, RESP_W=136, and the no-response index list {0,4,15} (also used by cmd_phys).
REQ-021 The watchdog SHALL be a sub-module cmd_watchdog (clear, enable, limit, expired).

Verification
REQ-022 req0 CMD8 (index 8, arg 0x1AA); ack_out after 3 cycles; strobe_out with response 136'h..01AA -> req0_grant once, resp_data matches, req0_done one cycle, resp_timeout=0.
REQ-023 req0_valid and req1_valid asserted in the same cycle, twice in a row -> grants req0 then req1; with req1 granted last, the next tie goes to req0.
REQ-024 req1 CMD0 (no response); ack_out, then serialReady=1 -> req1_done with resp_data=0, ack_in never asserted.
REQ-025 req0 CMD2; COMMAND_TIMEOUT=1 in WAIT_RESP -> req0_done with resp_timeout=1; WDT_CYCLES=16, ack_out never asserted -> ABORT with idle_in=1 one cycle, done at cycle 18 after grant, resp_timeout=1.
REQ-026 Reset asserted in WAIT_RESP -> no done pulse, all outputs 0, next req1 request is served while req0 is favoured only on ties.

Source files
------------

// File: rtl/cmd_arb_pkg.sv
// Shared definitions for the SD command arbiter and the command PHY:
// frame widths, arbiter state encoding and the commands that never get a response.
package cmd_arb_pkg;

    localparam int CMD_W  = 40;
    localparam int RESP_W = 136;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RESP,
        ACK,
        ABORT,
        DONE
    } arb_state_e;

    // CMD0, CMD4 and CMD15 complete once the line is free; no response frame follows.
    localparam int NO_RESP_N = 3;
    localparam logic [NO_RESP_N-1:0][5:0] NO_RESP_IDX = {6'd15, 6'd4, 6'd0};

    function automatic logic is_no_resp(input logic [5:0] idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NO_RESP_N; i++) begin
            if (idx == NO_RESP_IDX[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/cmd_watchdog.sv
// Per-command watchdog: counts enabled cycles since the last clear and
// flags expiry once the count reaches the limit (the count then holds).
module cmd_watchdog #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q >= limit_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)                     cnt_d = '0;
        else if (enable_i && !expired_o) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/cmd_arbiter.sv
// Two-requester round-robin arbiter in front of the SD command PHY: issues one
// command at a time, collects its response or timeout and reports completion.
module cmd_arbiter
    import cmd_arb_pkg::*;
#(
    parameter logic [15:0] WDT_CYCLES = 16'd2048
) (
    input  logic              sd_clock,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [CMD_W-1:0]  req0_cmd,
    output logic              req0_grant,
    output logic              req0_done,
    input  logic              req1_valid,
    input  logic [CMD_W-1:0]  req1_cmd,
    output logic              req1_grant,
    output logic              req1_done,
    output logic [RESP_W-1:0] resp_data,
    output logic              resp_timeout,
    output logic              strobe_in,
    output logic              ack_in,
    output logic              idle_in,
    output logic [CMD_W-1:0]  cmd_to_send,
    input  logic              ack_out,
    input  logic              strobe_out,
    input  logic [RESP_W-1:0] response,
    input  logic              serialReady,
    input  logic              COMMAND_TIMEOUT
);

    arb_state_e        state_q;
    logic              prio_q;     // 1: req1 wins a tie
    logic              owner_q;    // requester of the command in flight
    logic              req0_grant_q, req1_grant_q, req0_done_q, req1_done_q;
    logic [RESP_W-1:0] resp_data_q;
    logic              resp_timeout_q;
    logic              strobe_in_q, ack_in_q, idle_in_q;
    logic [CMD_W-1:0]  cmd_to_send_q;

    logic accept, pick1, wdt_expired;

    assign accept = (state_q == IDLE) && (req0_valid || req1_valid) && serialReady;
    assign pick1  = (req0_valid && req1_valid) ? prio_q : req1_valid;

    cmd_watchdog #(.CNT_W(16)) u_wdt (
        .clk_i     (sd_clock),
        .rst_i     (reset),
        .clear_i   (accept),
        .enable_i  ((state_q == ISSUE) || (state_q == WAIT_RESP)),
        .limit_i   (WDT_CYCLES),
        .expired_o (wdt_expired)
    );

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state_q        <= IDLE;
            prio_q         <= 1'b0;
            owner_q        <= 1'b0;
            req0_grant_q   <= 1'b0;
            req1_grant_q   <= 1'b0;
            req0_done_q    <= 1'b0;
            req1_done_q    <= 1'b0;
            resp_data_q    <= '0;
            resp_timeout_q <= 1'b0;
            strobe_in_q    <= 1'b0;
            ack_in_q       <= 1'b0;
            idle_in_q      <= 1'b0;
            cmd_to_send_q  <= '0;
        end else begin
            req0_grant_q <= 1'b0;
            req1_grant_q <= 1'b0;
            req0_done_q  <= 1'b0;
            req1_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    idle_in_q <= 1'b1;
                    if (accept) begin
                        state_q       <= ISSUE;
                        idle_in_q     <= 1'b0;
                        cmd_to_send_q <= pick1 ? req1_cmd : req0_cmd;
                        owner_q       <= pick1;
                        prio_q        <= ~pick1;
                        req0_grant_q  <= ~pick1;
                        req1_grant_q  <= pick1;
                    end
                end
                ISSUE: begin
                    // strobe rises one cycle after the grant; ack only counts while it is up
                    if (wdt_expired) begin
                        state_q     <= ABORT;
                        strobe_in_q <= 1'b0;
                        idle_in_q   <= 1'b1;
                    end else if (strobe_in_q && ack_out) begin
                        state_q     <= WAIT_RESP;
                        strobe_in_q <= 1'b0;
                    end else begin
                        strobe_in_q <= 1'b1;
                    end
                end
                WAIT_RESP: begin
                    if (wdt_expired) begin
                        state_q   <= ABORT;
                        idle_in_q <= 1'b1;
                    end else if (COMMAND_TIMEOUT) begin
                        state_q        <= DONE;
                        resp_data_q    <= '0;
                        resp_timeout_q <= 1'b1;
                        req0_done_q    <= ~owner_q;
                        req1_done_q    <= owner_q;
                    end else if (strobe_out) begin
                        state_q        <= ACK;
                        resp_data_q    <= response;
                        resp_timeout_q <= 1'b0;
                        ack_in_q       <= 1'b1;
                    end else if (is_no_resp(cmd_to_send_q[37:32]) && serialReady) begin
                        state_q        <= DONE;
                        resp_data_q    <= '0;
                        resp_timeout_q <= 1'b0;
                        req0_done_q    <= ~owner_q;
                        req1_done_q    <= owner_q;
                    end
                end
                ACK: begin
                    if (!strobe_out) begin
                        state_q     <= DONE;
                        ack_in_q    <= 1'b0;
                        req0_done_q <= ~owner_q;
                        req1_done_q <= owner_q;
                    end
                end
                ABORT: begin
                    state_q        <= DONE;
                    idle_in_q      <= 1'b0;
                    ack_in_q       <= 1'b0;
                    resp_data_q    <= '0;
                    resp_timeout_q <= 1'b1;
                    req0_done_q    <= ~owner_q;
                    req1_done_q    <= owner_q;
                end
                DONE: begin
                    state_q   <= IDLE;
                    idle_in_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req0_grant   = req0_grant_q;
    assign req1_grant   = req1_grant_q;
    assign req0_done    = req0_done_q;
    assign req1_done    = req1_done_q;
    assign resp_data    = resp_data_q;
    assign resp_timeout = resp_timeout_q;
    assign strobe_in    = strobe_in_q;
    assign ack_in       = ack_in_q;
    assign idle_in      = idle_in_q;
    assign cmd_to_send  = cmd_to_send_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed bench for cmd_arbiter: the bench plays both requesters and the command PHY,
// with expected values worked out by hand for each step.
module tb_cmd_arbiter;
    import cmd_arb_pkg::*;

    logic              sd_clock, reset;
    logic              req0_valid, req1_valid;
    logic [CMD_W-1:0]  req0_cmd, req1_cmd;
    logic              req0_grant, req0_done, req1_grant, req1_done;
    logic [RESP_W-1:0] resp_data;
    logic              resp_timeout, strobe_in, ack_in, idle_in;
    logic [CMD_W-1:0]  cmd_to_send;
    logic              ack_out, strobe_out, serialReady, COMMAND_TIMEOUT;
    logic [RESP_W-1:0] response;

    localparam logic [CMD_W-1:0]  CMD8  = {2'b01, 6'd8,  32'h0000_01AA};
    localparam logic [CMD_W-1:0]  CMD0  = {2'b01, 6'd0,  32'h0000_0000};
    localparam logic [CMD_W-1:0]  CMD2  = {2'b01, 6'd2,  32'h0000_0000};
    localparam logic [CMD_W-1:0]  CMDA  = {2'b01, 6'd17, 32'h0000_1000};
    localparam logic [CMD_W-1:0]  CMDB  = {2'b01, 6'd12, 32'h0000_0000};
    localparam logic [RESP_W-1:0] R8    = 136'h48_0000_01AA;
    localparam logic [RESP_W-1:0] RA    = 136'h11_0000_0900_DEAD_BEEF;
    localparam logic [RESP_W-1:0] RB    = 136'h0C_0000_0B00_CAFE_0001;

    cmd_arbiter #(.WDT_CYCLES(16'd16)) dut (
        .sd_clock(sd_clock), .reset(reset),
        .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_grant(req0_grant), .req0_done(req0_done),
        .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_grant(req1_grant), .req1_done(req1_done),
        .resp_data(resp_data), .resp_timeout(resp_timeout),
        .strobe_in(strobe_in), .ack_in(ack_in), .idle_in(idle_in), .cmd_to_send(cmd_to_send),
        .ack_out(ack_out), .strobe_out(strobe_out), .response(response),
        .serialReady(serialReady), .COMMAND_TIMEOUT(COMMAND_TIMEOUT)
    );

    initial sd_clock = 1'b0;
    always #5 sd_clock = ~sd_clock;

    int n_chk = 0, n_pass = 0;
    int g0 = 0, g1 = 0, d0 = 0, d1 = 0, ackn = 0, hot_err = 0;

    always @(negedge sd_clock) begin
        if (!reset) begin
            g0   <= g0 + int'(req0_grant);
            g1   <= g1 + int'(req1_grant);
            d0   <= d0 + int'(req0_done);
            d1   <= d1 + int'(req1_done);
            ackn <= ackn + int'(ack_in);
            if (int'(req0_grant) + int'(req1_grant) + int'(req0_done) + int'(req1_done) > 1)
                hot_err <= hot_err + 1;
        end
    end

    task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge sd_clock);
        #1;
    endtask

    // PHY side: wait for the strobe, then accept the command for one cycle
    task automatic phys_ack(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (strobe_in) begin seen = 1'b1; break; end
            tick();
        end
        chk({tag, "_strobe_seen"}, 136'(seen), 136'(1));
        ack_out = 1'b1;
        tick();
        ack_out = 1'b0;
    endtask

    task automatic phys_resp(input string tag, input logic [RESP_W-1:0] r);
        bit seen;
        seen = 1'b0;
        strobe_out = 1'b1;
        response   = r;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack_in) begin seen = 1'b1; break; end
        end
        chk({tag, "_ack_in_seen"}, 136'(seen), 136'(1));
        strobe_out = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic e0, input logic e1);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (req0_done || req1_done) break;
        end
        chk({tag, "_done0"}, 136'(req0_done), 136'(e0));
        chk({tag, "_done1"}, 136'(req1_done), 136'(e1));
    endtask

    int b_g0, b_d, b_ack;

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_cmd = '0; req1_cmd = '0;
        ack_out = 1'b0; strobe_out = 1'b0; response = '0;
        serialReady = 1'b0; COMMAND_TIMEOUT = 1'b0;
        repeat (3) tick();
        chk("rst_idle_in", 136'(idle_in), 136'(0));
        chk("rst_outs", 136'({req0_grant, req1_grant, req0_done, req1_done, strobe_in, ack_in, resp_timeout}), 136'(0));
        reset = 1'b0;
        tick();
        chk("post_rst_idle_in", 136'(idle_in), 136'(1));

        // ---- ties: req0 first after reset, then alternate
        req0_cmd = CMDA; req1_cmd = CMDB;
        req0_valid = 1'b1; req1_valid = 1'b1; serialReady = 1'b1;
        tick();
        chk("tie1_grants", 136'({req0_grant, req1_grant}), 136'(2'b10));
        chk("tie1_cmd", 136'(cmd_to_send), 136'(CMDA));
        chk("tie1_idle_low", 136'(idle_in), 136'(0));
        req0_valid = 1'b0;
        phys_ack("tie1");
        phys_resp("tie1", RA);
        wait_done("tie1", 1'b1, 1'b0);
        chk("tie1_resp", resp_data, RA);
        req0_valid = 1'b1;
        tick();
        chk("no_grant_in_done", 136'({req0_grant, req1_grant}), 136'(0));
        chk("done_to_idle", 136'(idle_in), 136'(1));
        tick();
        chk("tie2_grants", 136'({req0_grant, req1_grant}), 136'(2'b01));
        chk("tie2_cmd", 136'(cmd_to_send), 136'(CMDB));
        req1_valid = 1'b0;
        phys_ack("tie2");
        phys_resp("tie2", RB);
        wait_done("tie2", 1'b0, 1'b1);
        chk("tie2_resp", resp_data, RB);
        req1_valid = 1'b1;
        tick();
        tick();
        chk("tie3_grants", 136'({req0_grant, req1_grant}), 136'(2'b10));
        req0_valid = 1'b0; req1_valid = 1'b0;
        phys_ack("tie3");
        phys_resp("tie3", RA);
        wait_done("tie3", 1'b1, 1'b0);
        tick();

        // ---- CMD8 on req0, ack three cycles after the strobe
        b_g0 = g0;
        req0_cmd = CMD8; req0_valid = 1'b1;
        tick();
        chk("c8_grant", 136'(req0_grant), 136'(1));
        chk("c8_strobe_not_yet", 136'(strobe_in), 136'(0));
        req0_valid = 1'b0;
        tick();
        chk("c8_strobe_lat1", 136'(strobe_in), 136'(1));
        chk("c8_grant_pulse", 136'(req0_grant), 136'(0));
        tick(); tick();
        ack_out = 1'b1;
        tick();
        ack_out = 1'b0;
        chk("c8_strobe_drop", 136'(strobe_in), 136'(0));
        strobe_out = 1'b1; response = R8;
        tick();
        chk("c8_ack_in", 136'(ack_in), 136'(1));
        chk("c8_resp_latched", resp_data, R8);
        strobe_out = 1'b0;
        tick();
        chk("c8_done", 136'({req0_done, req1_done}), 136'(2'b10));
        chk("c8_ack_in_low", 136'(ack_in), 136'(0));
        chk("c8_resp", resp_data, R8);
        chk("c8_tmo", 136'(resp_timeout), 136'(0));
        tick();
        chk("c8_done_1cyc", 136'(req0_done), 136'(0));
        chk("c8_resp_held", resp_data, R8);
        chk("c8_grant_once", 136'(g0 - b_g0), 136'(1));

        // ---- line busy, then request withdrawn before any grant
        serialReady = 1'b0; req0_valid = 1'b1;
        tick();
        chk("busy_no_grant", 136'({req0_grant, req1_grant}), 136'(0));
        req0_valid = 1'b0; serialReady = 1'b1;
        tick();
        chk("withdrawn_no_grant", 136'({req0_grant, req1_grant, idle_in}), 136'(3'b001));

        // ---- CMD0 on req1: completes on serialReady, no ack_in
        b_ack = ackn;
        req1_cmd = CMD0; req1_valid = 1'b1;
        tick();
        chk("c0_grant", 136'(req1_grant), 136'(1));
        req1_valid = 1'b0; serialReady = 1'b0;
        phys_ack("c0");
        tick();
        chk("c0_wait_line", 136'({req0_done, req1_done}), 136'(0));
        serialReady = 1'b1;
        tick();
        chk("c0_done", 136'({req0_done, req1_done}), 136'(2'b01));
        chk("c0_resp_zero", resp_data, 136'(0));
        chk("c0_tmo", 136'(resp_timeout), 136'(0));
        tick();
        chk("c0_no_ack_in", 136'(ackn - b_ack), 136'(0));

        // ---- CMD2: COMMAND_TIMEOUT outranks a simultaneous response strobe
        req0_cmd = CMD2; req0_valid = 1'b1;
        tick();
        chk("c2_grant", 136'(req0_grant), 136'(1));
        req0_valid = 1'b0;
        phys_ack("c2");
        COMMAND_TIMEOUT = 1'b1; strobe_out = 1'b1; response = RA;
        tick();
        COMMAND_TIMEOUT = 1'b0; strobe_out = 1'b0;
        chk("c2_done", 136'(req0_done), 136'(1));
        chk("c2_tmo", 136'(resp_timeout), 136'(1));
        chk("c2_no_ack", 136'(ack_in), 136'(0));
        tick();

        // ---- watchdog: never acked, ABORT in cycle 17, done in cycle 18
        req0_cmd = CMD2; req0_valid = 1'b1;
        tick();
        chk("wdt_grant", 136'(req0_grant), 136'(1));
        req0_valid = 1'b0;
        repeat (16) tick();
        chk("wdt_c16", 136'({strobe_in, idle_in, req0_done}), 136'(3'b100));
        tick();
        chk("wdt_abort_c17", 136'({strobe_in, ack_in, idle_in, req0_done}), 136'(4'b0010));
        tick();
        chk("wdt_done_c18", 136'({req0_done, resp_timeout, idle_in}), 136'(3'b110));
        chk("wdt_resp_zero", resp_data, 136'(0));
        tick();
        chk("wdt_back_idle", 136'({req0_done, idle_in}), 136'(2'b01));

        // ---- reset while waiting for a response
        req0_cmd = CMDA; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        phys_ack("rst");
        b_d = d0 + d1;
        reset = 1'b1;
        tick();
        chk("midrst_outs", 136'({req0_grant, req1_grant, req0_done, req1_done, strobe_in, ack_in, idle_in, resp_timeout}), 136'(0));
        chk("midrst_cmd", 136'(cmd_to_send), 136'(0));
        chk("midrst_resp", resp_data, 136'(0));
        reset = 1'b0;
        req1_cmd = CMDB; req1_valid = 1'b1;
        tick();
        chk("midrst_no_done", 136'(d0 + d1 - b_d), 136'(0));
        chk("post_rst_req1_grant", 136'({req0_grant, req1_grant}), 136'(2'b01));
        chk("post_rst_req1_cmd", 136'(cmd_to_send), 136'(CMDB));
        req1_valid = 1'b0;
        phys_ack("rst2");
        COMMAND_TIMEOUT = 1'b1;
        wait_done("rst2", 1'b0, 1'b1);
        COMMAND_TIMEOUT = 1'b0;
        tick();

        chk("one_hot_pulses", 136'(hot_err), 136'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not reach its end");
        $fatal(1);
    end

endmodule
